// File: rtl/qsys_sw_pkg.sv
// Shared definitions for the slide-switch edge controller: register word
// addresses, edge-mode encoding and the debounce counter width helper.
// Optional feature macro used by the block: QSYS_SW_DEBOUNCE_EN.
package qsys_sw_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    // Encoding 3 is accepted in CTRL and behaves like EDGE_ANY.
    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

    // Bits needed to hold a count of 0..ticks-1 (at least one bit).
    function automatic int unsigned qsys_sw_cnt_width(input int unsigned ticks);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(ticks)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/qsys_sw_debounce_bit.sv
// Single-bit debouncer: accepts a new synchronised level only after it has
// been stable for DB_TICKS consecutive prescaler ticks. Built only when
// QSYS_SW_DEBOUNCE_EN is defined.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   armed       when low the output simply follows sync_in
//   tick        one-cycle prescaler strobe
//   sync_in     synchronised switch level
//   debounced   registered accepted level
//   flip_c      combinational: debounced changes on this clock edge (armed only)
module qsys_sw_debounce_bit
    import qsys_sw_pkg::*;
#(
    parameter int unsigned DB_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic armed,
    input  logic tick,
    input  logic sync_in,
    output logic debounced,
    output logic flip_c
);

    localparam int unsigned      CNT_W    = qsys_sw_cnt_width(DB_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

    logic             debounced_q, debounced_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Hold-time counter; any return to the accepted level restarts it.
    always_comb begin
        debounced_d = debounced_q;
        cnt_d       = cnt_q;
        flip_c      = 1'b0;
        if (!armed) begin
            debounced_d = sync_in;
            cnt_d       = '0;
        end else if (sync_in == debounced_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                debounced_d = sync_in;
                cnt_d       = '0;
                flip_c      = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debounced_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            debounced_q <= debounced_d;
            cnt_q       <= cnt_d;
        end
    end

    assign debounced = debounced_q;

endmodule

// File: rtl/qsys_sw_edge_ctrl.sv
// Avalon-MM slide-switch controller: 2-FF synchroniser, optional debounce,
// sticky per-bit edge capture and a masked level interrupt.
// Build option: QSYS_SW_DEBOUNCE_EN adds the tick prescaler and per-bit
// debounce counters; without it the synchronised level is taken directly.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   address/write/writedata    register write port (word addressed)
//   read                       informational; readdata is valid every cycle
//   readdata                   registered read data, one cycle after address
//   in_port                    raw asynchronous switch levels
//   irq                        registered |(edge_cap & irq_mask)
module qsys_sw_edge_ctrl
    import qsys_sw_pkg::*;
#(
    parameter int unsigned WIDTH    = 18,
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned DB_TICKS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic             read,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32 || TICK_DIV < 2 || DB_TICKS < 1 || DB_TICKS > 255) begin : g_cfg_err
        $error("qsys_sw_edge_ctrl: parameter out of range");
    end

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [1:0]       arm_cnt_q, arm_cnt_d;
    logic             armed_q, armed_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [1:0]       edge_mode_q, edge_mode_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] db_level;
    logic [WIDTH-1:0] db_flip_c;
    logic [WIDTH-1:0] rise_c, fall_c, edge_new_c, w1c_c;

`ifdef QSYS_SW_DEBOUNCE_EN
    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_c;

    // Free-running tick prescaler.
    always_comb begin
        tick_c = (pre_q == PRE_W'(TICK_DIV - 1));
        pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_db
        qsys_sw_debounce_bit #(
            .DB_TICKS (DB_TICKS)
        ) u_db (
            .clk       (clk),
            .reset     (reset),
            .armed     (armed_q),
            .tick      (tick_c),
            .sync_in   (sync2_q[i]),
            .debounced (db_level[i]),
            .flip_c    (db_flip_c[i])
        );
    end
`else
    logic [WIDTH-1:0] debounced_q, debounced_d;

    // Without debounce the synchronised level is accepted every cycle.
    always_comb begin
        debounced_d = sync2_q;
        db_flip_c   = armed_q ? (sync2_q ^ debounced_q) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debounced_q <= '0;
        end else begin
            debounced_q <= debounced_d;
        end
    end

    assign db_level = debounced_q;
`endif

    // Synchroniser, arming, edge capture, register file and irq.
    always_comb begin
        sync1_d     = in_port;
        sync2_d     = sync1_q;
        arm_cnt_d   = arm_cnt_q;
        armed_d     = armed_q;
        irq_mask_d  = irq_mask_q;
        edge_mode_d = edge_mode_q;
        readdata_d  = '0;

        // Armed on the third clock after reset release; sync and debounced
        // have settled by then, so no edge is seen from reset values.
        if (!armed_q) begin
            if (arm_cnt_q == 2'd2) begin
                armed_d = 1'b1;
            end else begin
                arm_cnt_d = arm_cnt_q + 2'd1;
            end
        end

        // A flip always moves debounced to the current sync level.
        rise_c = db_flip_c & sync2_q;
        fall_c = db_flip_c & ~sync2_q;
        case (edge_mode_q)
            EDGE_RISE: edge_new_c = rise_c;
            EDGE_FALL: edge_new_c = fall_c;
            default:   edge_new_c = db_flip_c;
        endcase

        // New edges override a same-cycle W1C.
        w1c_c      = (write && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        edge_cap_d = (edge_cap_q & ~w1c_c) | edge_new_c;

        if (write && address == ADDR_IRQMASK) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (write && address == ADDR_CTRL) begin
            edge_mode_d = writedata[1:0];
        end

        case (address)
            ADDR_DATA:    readdata_d = 32'(db_level);
            ADDR_IRQMASK: readdata_d = 32'(irq_mask_q);
            ADDR_EDGECAP: readdata_d = 32'(edge_cap_q);
            default:      readdata_d = {30'd0, edge_mode_q};
        endcase

        irq_d = |(edge_cap_q & irq_mask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            arm_cnt_q   <= 2'd0;
            armed_q     <= 1'b0;
            edge_cap_q  <= '0;
            irq_mask_q  <= '0;
            edge_mode_q <= 2'd0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            arm_cnt_q   <= arm_cnt_d;
            armed_q     <= armed_d;
            edge_cap_q  <= edge_cap_d;
            irq_mask_q  <= irq_mask_d;
            edge_mode_q <= edge_mode_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

    // read is informational and writedata bits above WIDTH are ignored.
    logic unused_c;
    assign unused_c = ^{read, writedata};

endmodule

// File: tb/tb_qsys_sw_edge_ctrl.sv
// Randomised bench for qsys_sw_edge_ctrl with a behavioural reference model.
// Works in both builds (QSYS_SW_DEBOUNCE_EN defined or not).
module tb_qsys_sw_edge_ctrl;

    localparam int unsigned W   = 18;
    localparam int unsigned TD  = 4;
    localparam int unsigned DBT = 3;
    localparam logic [1:0] A_DATA = 2'd0, A_MASK = 2'd1, A_CAP = 2'd2, A_CTRL = 2'd3;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   address;
    logic         write;
    logic [31:0]  writedata;
    logic         read;
    logic [31:0]  readdata;
    logic [W-1:0] in_port;
    logic         irq;

    always #5 clk = ~clk;

    qsys_sw_edge_ctrl #(
        .WIDTH    (W),
        .TICK_DIV (TD),
        .DB_TICKS (DBT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .read      (read),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: clocks since release, sync history, accepted
    // levels, ticks each pending level has survived, and register contents.
    int           m_cyc;
    logic [W-1:0] m_s1, m_s2, m_db, m_cap, m_mask, m_last_edge;
    logic [1:0]   m_mode;
    int           m_hold [W];
    logic [31:0]  m_rd;
    logic         m_irq;
    logic [W-1:0] cur_in;

    task automatic model_reset();
        m_cyc = 0; m_s1 = '0; m_s2 = '0; m_db = '0; m_cap = '0;
        m_mask = '0; m_mode = 2'd0; m_last_edge = '0; m_rd = '0; m_irq = 1'b0;
        for (int i = 0; i < int'(W); i++) m_hold[i] = 0;
    endtask

    task automatic model_step();
        logic [W-1:0] s, flip, nd, rise, fall, edges, clr;
        logic tick, armed;
        s     = m_s2;
        tick  = ((m_cyc % TD) == TD - 1);
        armed = (m_cyc >= 3);
        case (address)
            A_DATA:  m_rd = 32'(m_db);
            A_MASK:  m_rd = 32'(m_mask);
            A_CAP:   m_rd = 32'(m_cap);
            default: m_rd = {30'd0, m_mode};
        endcase
        m_irq = |(m_cap & m_mask);
        flip  = '0;
        for (int i = 0; i < int'(W); i++) begin
`ifdef QSYS_SW_DEBOUNCE_EN
            if (!armed || s[i] == m_db[i]) begin
                m_hold[i] = 0;
            end else if (tick) begin
                m_hold[i] = m_hold[i] + 1;
                if (m_hold[i] == DBT) begin
                    flip[i]   = 1'b1;
                    m_hold[i] = 0;
                end
            end
`else
            flip[i] = armed && (s[i] != m_db[i]);
`endif
        end
        nd    = armed ? (m_db ^ flip) : s;
        rise  = flip & nd;
        fall  = flip & ~nd;
        edges = (m_mode == 2'd0) ? rise : (m_mode == 2'd1) ? fall : flip;
        clr   = (write && address == A_CAP) ? writedata[W-1:0] : '0;
        m_cap = (m_cap & ~clr) | edges;
        m_last_edge = edges;
        if (write && address == A_MASK) m_mask = writedata[W-1:0];
        if (write && address == A_CTRL) m_mode = writedata[1:0];
        m_db  = nd;
        m_s2  = m_s1;
        m_s1  = in_port;
        m_cyc = m_cyc + 1;
    endtask

    // One bus cycle; outputs are compared against the model 1 ns after the edge.
    task automatic cyc(input logic [1:0] a, input logic w, input logic [31:0] wd);
        @(negedge clk);
        reset = 1'b0; address = a; write = w; writedata = wd; in_port = cur_in;
        @(posedge clk);
        model_step();
        #1;
        check_eq("readdata", readdata, m_rd);
        check_eq("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(2'($urandom_range(0, 3)), 1'b0, 32'd0);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        cyc(a, 1'b0, 32'd0);
        v = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(a, 1'b1, d);
    endtask

    task automatic wait_data(input int idx, input logic val, input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 80 && !ok; k++) begin
            cyc(A_DATA, 1'b0, 32'd0);
            ok = (readdata[idx] === val);
        end
        check_eq(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic reset_hold(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check_eq("rst_readdata", readdata, 32'd0);
            check_eq("rst_irq", {31'd0, irq}, 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        bit hit;
        address = 2'd0; write = 1'b0; writedata = '0; read = 1'b1;
        cur_in = 18'h2A5A5; in_port = cur_in; reset = 1'b1;
        model_reset();
        reset_hold(3);

        // Reset with a static pattern: DATA follows once armed, nothing captured.
        idle(6);
        rd(A_DATA, v);  check_eq("t1_data", v, 32'h0002A5A5);
        rd(A_CAP, v);   check_eq("t1_edgecap", v, 32'd0);
        check_eq("t1_irq", {31'd0, irq}, 32'd0);

        // Falling to all-zero is not captured in rise mode.
        cur_in = '0;
        wait_data(0, 1'b0, "t2_fall_seen");
        rd(A_DATA, v);  check_eq("t2_data_zero", v, 32'd0);
        rd(A_CAP, v);   check_eq("t2_cap_zero", v, 32'd0);

        // Rising edge on bit0, masked in: capture and irq.
        wr(A_CTRL, 32'd0);
        wr(A_MASK, 32'd1);
        cur_in[0] = 1'b1;
        wait_data(0, 1'b1, "t2_rise_seen");
        rd(A_CAP, v);   check_eq("t2_edgecap", v, 32'd1);
        check_eq("t2_irq", {31'd0, irq}, 32'd1);

        // Short glitch on bit5: filtered with debounce, captured without.
        wr(A_CAP, 32'd1);
        idle(2);
        cur_in[5] = 1'b1;
        idle(5);
        cur_in[5] = 1'b0;
        idle(20);
        rd(A_DATA, v);  check_eq("t3_data", v, 32'd1);
        rd(A_CAP, v);
`ifdef QSYS_SW_DEBOUNCE_EN
        check_eq("t3_edgecap", v, 32'd0);
`else
        check_eq("t3_edgecap", v, 32'h20);
`endif
        check_eq("t3_irq", {31'd0, irq}, 32'd0);

        // W1C in the same cycle as a new edge: the set wins.
        wr(A_CAP, 32'h3FFFF);
        cur_in[0] = 1'b0;
        wait_data(0, 1'b0, "t4_fall_seen");
        cur_in[0] = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 80 && !hit; k++) begin
            wr(A_CAP, 32'd1);
            hit = m_last_edge[0];
        end
        check_eq("t4_edge_seen", {31'd0, hit}, 32'd1);
        rd(A_CAP, v);   check_eq("t4_set_wins", v, 32'd1);
        wr(A_CAP, 32'd1);
        check_eq("t4_irq_lag", {31'd0, irq}, 32'd1);
        rd(A_CAP, v);   check_eq("t4_cleared", v, 32'd0);
        check_eq("t4_irq_drop", {31'd0, irq}, 32'd0);

        // Any-change mode on bit17, then fall-only ignores a rise.
        wr(A_CTRL, 32'd2);
        cur_in[17] = 1'b1;
        wait_data(17, 1'b1, "t5_rise_seen");
        rd(A_CAP, v);   check_eq("t5_any_rise", v, 32'h20000);
        wr(A_CAP, 32'h20000);
        cur_in[17] = 1'b0;
        wait_data(17, 1'b0, "t5_fall_seen");
        rd(A_CAP, v);   check_eq("t5_any_fall", v, 32'h20000);
        wr(A_CAP, 32'h20000);
        wr(A_CTRL, 32'hFFFF_FFFD);
        cur_in[17] = 1'b1;
        wait_data(17, 1'b1, "t5_rise2_seen");
        idle(2);
        rd(A_CAP, v);   check_eq("t5_fall_only", v, 32'd0);
        rd(A_CTRL, v);  check_eq("t5_ctrl", v, 32'd1);

        // Reset in the middle of a debounce with irq pending.
        wr(A_CTRL, 32'd2);
        cur_in[17] = 1'b0;
        wait_data(17, 1'b0, "t6_fall_seen");
        wr(A_MASK, 32'hFFFF_FFFF);
        rd(A_MASK, v);  check_eq("t6_mask", v, 32'h3FFFF);
        check_eq("t6_irq_before", {31'd0, irq}, 32'd1);
        cur_in[3] = 1'b1;
        idle(6);
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_eq("t6_async_readdata", readdata, 32'd0);
        check_eq("t6_async_irq", {31'd0, irq}, 32'd0);
        reset_hold(2);
        idle(8);
        rd(A_DATA, v);  check_eq("t6_data", v, 32'(cur_in));
        rd(A_CAP, v);   check_eq("t6_no_edge", v, 32'd0);
        check_eq("t6_irq", {31'd0, irq}, 32'd0);

        // Random traffic checked cycle by cycle against the model.
        wr(A_MASK, $urandom);
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    for (int b = 0; b < int'($urandom_range(1, 3)); b++)
                        cur_in[$urandom_range(0, W - 1)] ^= 1'b1;
                    idle($urandom_range(1, 12));
                end
                3: begin
                    int bi;
                    bi = $urandom_range(0, W - 1);
                    cur_in[bi] ^= 1'b1;
                    idle($urandom_range(1, 8));
                    cur_in[bi] ^= 1'b1;
                    idle($urandom_range(1, 4));
                end
                4: wr(A_CTRL, $urandom);
                5: wr(A_CAP, $urandom);
                6: wr(A_MASK, $urandom);
                7: wr(A_DATA, $urandom);
                default: idle($urandom_range(1, 20));
            endcase
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
